// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: WIDTH-step shift-add multiply and
// restoring divide on operand magnitudes, followed by a sign-fixup cycle that writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             multordiv,
  input  logic             sgn,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hlwrite,
  input  logic             hlsel,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_div, op_sgn, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               accept;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_wide_if(input logic [2*WIDTH-1:0] v,
                                                        input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: multiply adds the multiplicand on the current multiplier LSB and shifts
  // right; divide shifts {rem,quot} left and keeps the trial difference when non-negative.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, b_mag};
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (op_div) begin
      if (!div_diff[WIDTH+1]) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                    acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = negate_wide_if(acc, op_sgn && (sign_a ^ sign_b));
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (op_div) begin
      fix_hi = negate_if(acc[2*WIDTH-1:WIDTH], op_sgn && sign_a);
      fix_lo = negate_if(acc[WIDTH-1:0], op_sgn && (sign_a ^ sign_b));
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      if (accept)             cnt <= CNT_W'(WIDTH);
      else if (state == CALC) cnt <= cnt - 1'b1;
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (state == IDLE && !start && hlwrite) begin
        if (hlsel) hi <= wd;
        else       lo <= wd;
      end
    end
  end

  // Operand and working registers: only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div   <= multordiv;
      op_sgn   <= sgn;
      sign_a   <= sgn && srca[WIDTH-1];
      sign_b   <= sgn && srcb[WIDTH-1];
      div_zero <= (srcb == '0);
      a_raw    <= srca;
      a_mag    <= magnitude(srca, sgn);
      b_mag    <= magnitude(srcb, sgn);
      acc      <= {{WIDTH{1'b0}}, (multordiv ? magnitude(srca, sgn) : magnitude(srcb, sgn))};
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: arithmetic results, latency, HI/LO direct writes,
// ignored starts, back-to-back issue and reset abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, multordiv, sgn, hlwrite, hlsel;
  logic [31:0] srca, srcb, wd;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .multordiv(multordiv), .sgn(sgn),
    .srca(srca), .srcb(srcb), .hlwrite(hlwrite), .hlsel(hlsel), .wd(wd),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation for one cycle, then scrambles the operands.
  task automatic issue(input logic md, input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; multordiv = md; sgn = s; srca = a; srcb = b;
    step();
    start = 1'b0; srca = $urandom; srcb = $urandom;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b required 0/0/0/0", hi, lo, busy, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_multu_max();
    int n;
    issue(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    checks++;
    if (n !== 33) begin failures++; $display("FAIL multu_busy_len: got %0d required 33", n); end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL multu_done: got %b required 1", done); end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      failures++; $display("FAIL multu_max: hi=%h lo=%h required fffffffe 00000001", hi, lo);
    end
    step();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_mul();
    int n;
    logic [31:0] a_t [3] = '{32'hFFFFFFFD, 32'h80000000, 32'h12345678};
    logic [31:0] b_t [3] = '{32'h00000005, 32'h80000000, 32'h00000010};
    logic        s_t [3] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] e_t [3] = '{64'hFFFFFFFF_FFFFFFF1, 64'h40000000_00000000, 64'h00000001_23456780};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, s_t[i], a_t[i], b_t[i]);
      wait_idle(n);
      checks++;
      if ({hi, lo} !== e_t[i] || done !== 1'b1) begin
        failures++;
        $display("FAIL mul_%0d: hi=%h lo=%h done=%b required %h done=1", i, hi, lo, done, e_t[i]);
      end
      step();
    end
  endtask

  task automatic test_div();
    int n;
    logic [31:0] a_t [5] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFFF, 32'h00000007};
    logic [31:0] b_t [5] = '{32'h00000002, 32'd7, 32'hFFFFFFFF, 32'h00000010, 32'hFFFFFFFE};
    logic        s_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] eh_t[5] = '{32'hFFFFFFFF, 32'd2, 32'h0, 32'hF, 32'h1};
    logic [31:0] el_t[5] = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'h0FFFFFFF, 32'hFFFFFFFD};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, s_t[i], a_t[i], b_t[i]);
      wait_idle(n);
      checks++;
      if (hi !== eh_t[i] || lo !== el_t[i] || n !== 33) begin
        failures++;
        $display("FAIL div_%0d: hi=%h lo=%h busy=%0d required %h %h 33", i, hi, lo, n, eh_t[i], el_t[i]);
      end
      step();
    end
  endtask

  task automatic test_div_zero();
    int n;
    logic [31:0] a_t [3] = '{32'h12345678, 32'h12345678, 32'h80000001};
    logic        s_t [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, s_t[i], a_t[i], 32'h0);
      wait_idle(n);
      checks++;
      if (hi !== a_t[i] || lo !== 32'hFFFFFFFF || n !== 33 || done !== 1'b1) begin
        failures++;
        $display("FAIL div_zero_%0d: hi=%h lo=%h busy=%0d done=%b required %h ffffffff 33 1",
                 i, hi, lo, n, done, a_t[i]);
      end
      step();
    end
  endtask

  task automatic test_hlwrite();
    int n;
    logic [31:0] lo_before;
    lo_before = lo;
    hlwrite = 1'b1; hlsel = 1'b1; wd = 32'hA5A5A5A5;
    step();
    hlwrite = 1'b0;
    checks++;
    if (hi !== 32'hA5A5A5A5 || lo !== lo_before) begin
      failures++; $display("FAIL hlwrite_hi: hi=%h lo=%h required a5a5a5a5 %h", hi, lo, lo_before);
    end
    hlwrite = 1'b1; hlsel = 1'b0; wd = 32'h5A5A5A5A;
    step();
    hlwrite = 1'b0;
    checks++;
    if (lo !== 32'h5A5A5A5A || hi !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL hlwrite_lo: hi=%h lo=%h required a5a5a5a5 5a5a5a5a", hi, lo);
    end
    // Writes attempted while busy must be dropped.
    issue(1'b0, 1'b0, 32'd2, 32'd3);
    hlwrite = 1'b1; hlsel = 1'b0; wd = 32'hDEADBEEF;
    step();
    hlsel = 1'b1;
    step();
    hlwrite = 1'b0;
    checks++;
    if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) begin
      failures++; $display("FAIL hlwrite_busy_hold: hi=%h lo=%h required a5a5a5a5 5a5a5a5a", hi, lo);
    end
    wait_idle(n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      failures++; $display("FAIL hlwrite_busy: hi=%h lo=%h required 0 6", hi, lo);
    end
    step();
    // Start and hlwrite together: start wins.
    hlwrite = 1'b1; hlsel = 1'b1; wd = 32'h0000CAFE;
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    hlwrite = 1'b0;
    checks++;
    if (hi !== 32'h0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_hlwrite_drop: hi=%h busy=%b required 0 1", hi, busy);
    end
    wait_idle(n);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      failures++; $display("FAIL start_hlwrite_op: hi=%h lo=%h required 2 14", hi, lo);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int n;
    issue(1'b0, 1'b0, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) step();
    start = 1'b1; multordiv = 1'b1; srca = 32'd7; srcb = 32'd9;
    step();
    start = 1'b0;
    wait_idle(n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd12 || n + 6 !== 33) begin
      failures++;
      $display("FAIL start_ignored: hi=%h lo=%h busy=%0d required 0 12 33", hi, lo, n + 6);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    issue(1'b0, 1'b0, 32'd5, 32'd6);
    wait_idle(n);
    checks++;
    if (lo !== 32'd30 || done !== 1'b1) begin
      failures++; $display("FAIL b2b_first: lo=%h done=%b required 1e 1", lo, done);
    end
    issue(1'b1, 1'b0, 32'd50, 32'd3);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
    wait_idle(n);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd16 || n !== 33 || done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: hi=%h lo=%h busy=%0d done=%b required 2 10 33 1", hi, lo, n, done);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int pulses;
    hlwrite = 1'b1; hlsel = 1'b1; wd = 32'h11111111;
    step();
    hlsel = 1'b0; wd = 32'h22222222;
    step();
    hlwrite = 1'b0;
    issue(1'b0, 1'b0, 32'hFFFFFFFF, 32'h3);
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_abort_quiet: activity=%0d hi=%h lo=%h required 0 0 0", pulses, hi, lo);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; multordiv = 1'b0; sgn = 1'b0;
    srca = '0; srcb = '0; hlwrite = 1'b0; hlsel = 1'b0; wd = '0;
    #1;
    test_reset();
    test_multu_max();
    test_mul();
    test_div();
    test_div_zero();
    test_hlwrite();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, in the execute stage directly downstream of the main decoder. It consumes the decoder's `multordiv` and `hlwrite` controls, carried through the ID/EX register, together with the ALU operands. It runs MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and raises `busy` so the hazard unit stalls any MFHI/MFLO or new mult/div. It also services MTHI/MTLO direct writes.

## Interface
- WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  issue a mult/div this cycle (EX-stage valid mult/div instruction).
- multordiv  in  1  0 = multiply, 1 = divide; sampled with start.
- sgn  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU); sampled with start.
- srca  in  WIDTH  multiplicand / dividend.
- srcb  in  WIDTH  multiplier / divisor.
- hlwrite  in  1  direct write of wd into HI or LO.
- hlsel  in  1  direct-write target: 0 = LO, 1 = HI.
- wd  in  WIDTH  direct-write data.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).
- busy  out  1  operation in progress; HI/LO not valid for reads.
- done  out  1  one-cycle pulse: HI/LO just updated by a completed operation.

## Operation
- FSM states: IDLE, CALC, FIX. `busy` = (state != IDLE), decoded from state register.
- IDLE: start=1 accepts: latch op, sgn, |srca|, |srcb| (magnitudes if sgn, raw if not), sign bits, zero-divisor flag; iteration counter := WIDTH; go to CALC.
- CALC: one step per cycle; counter decrements; leave for FIX when counter reaches 0 after the WIDTH-th step.
  - Multiply: 2*WIDTH-bit shift-add on magnitudes, one multiplier bit per step, LSB first.
  - Divide: restoring; shift {rem,quot} left 1, trial-subtract divisor, set quotient bit if non-negative.
- FIX: apply signs and write HI/LO, then go to IDLE.
  - Signed multiply: negate the 2*WIDTH product if sign(a)^sign(b).
  - Signed divide: quotient negated if sign(a)^sign(b); remainder takes sign of dividend.
  - Divide by zero (either signedness): HI := srca as issued, LO := all ones. This overrides sign fixup. Full latency is still taken.
  - Signed 0x80000000 / -1: LO := 0x80000000, HI := 0.
- done is registered: high in the first IDLE cycle after FIX, and only then.
- start while busy: ignored. The hazard unit must not assert it.
- hlwrite: honoured only in IDLE with start=0; writes wd to the selected register at the edge. If start=1 in the same cycle, start wins and the write is dropped. hlwrite while busy is ignored.
- hi/lo change only on reset, FIX, or an accepted hlwrite.

## Timing
- Reset: hi=0, lo=0, busy=0, done=0, state=IDLE. Reset during CALC/FIX aborts with no HI/LO update and no done pulse.
- Accept at edge ending cycle N. CALC occupies cycles N+1..N+WIDTH. FIX occupies N+WIDTH+1, and HI/LO are written at the end of that cycle.
- busy=1 in cycles N+1..N+WIDTH+1.
- In cycle N+WIDTH+2: busy=0, done=1, new hi/lo visible.
- Latency start-to-result = WIDTH+2 cycles (34 for WIDTH=32). Issue interval = WIDTH+2; a new start in the done cycle is accepted.
- busy is 0 in the accept cycle N itself. The hazard unit must therefore also stall on start for MFHI/MFLO in the following instruction.
- Operands srca/srcb need only be valid in cycle N.

## Test plan
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 34 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses one cycle, busy high exactly 33 cycles.
- MULT -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x12345678 / 0 (sgn=1 and sgn=0) -> hi=0x12345678, lo=0xFFFFFFFF after full latency; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- hlwrite hlsel=1 wd=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle, lo unchanged. hlwrite during busy -> no change. start+hlwrite same cycle -> write dropped, op runs.
- Assert start mid-operation with different operands -> ignored, original result delivered. Back-to-back start in the done cycle -> second result 34 cycles later.
- Reset asserted in CALC cycle 10 -> next cycle busy=0, done=0, hi=lo=0. No done pulse follows.
